// File: rtl/uart_fifo_pkg.sv
// Shared defaults and helpers for the UART FIFO: word/address widths, level width,
// and the legal ranges of the almost-full/almost-empty thresholds.
package uart_fifo_pkg;

  localparam int unsigned DefB = 8;
  localparam int unsigned DefW = 4;

  // almost_full threshold must lie in 1..D, almost_empty in 0..D-1.
  localparam int unsigned AfMin = 1;
  localparam int unsigned AeMin = 0;

  function automatic int unsigned lvl_width(input int unsigned w);
    return w + 1;
  endfunction

  function automatic int unsigned af_max(input int unsigned w);
    return 1 << w;
  endfunction

  function automatic int unsigned ae_max(input int unsigned w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/fifo_reg_file.sv
// Dual-port register array: one synchronous write port, one combinational read port.
// Contents are deliberately not reset.
module fifo_reg_file #(
  parameter int unsigned B = 8,
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         we_i,
  input  logic [W-1:0] waddr_i,
  input  logic [B-1:0] wdata_i,
  input  logic [W-1:0] raddr_i,
  output logic [B-1:0] rdata_o
);

  logic [B-1:0] mem_q [2**W];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_level.sv
// Show-ahead synchronous FIFO with occupancy level, thresholds and flush.
// Sticky overflow/underflow flags and err_clr exist only when UART_FIFO_ERR_EN is defined.
module fifo_level
  import uart_fifo_pkg::*;
#(
  parameter int unsigned B      = DefB,
  parameter int unsigned W      = DefW,
  parameter int unsigned AF_LVL = (1 << W) - 2,
  parameter int unsigned AE_LVL = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    flush,
  input  logic                    wr,
  input  logic [B-1:0]            w_data,
  input  logic                    rd,
`ifdef UART_FIFO_ERR_EN
  input  logic                    err_clr,
  output logic                    overflow,
  output logic                    underflow,
`endif
  output logic [B-1:0]            r_data,
  output logic                    empty,
  output logic                    full,
  output logic                    almost_empty,
  output logic                    almost_full,
  output logic [lvl_width(W)-1:0] level
);

  localparam int unsigned D  = 1 << W;
  localparam int unsigned LW = lvl_width(W);

  if (AF_LVL < AfMin || AF_LVL > af_max(W)) begin : g_af_range_err
    $error("fifo_level: AF_LVL out of range 1..2**W");
  end
  if (AE_LVL < AeMin || AE_LVL > ae_max(W)) begin : g_ae_range_err
    $error("fifo_level: AE_LVL out of range 0..2**W-1");
  end

  logic [W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          ae_q, ae_d;
  logic          af_q, af_d;
  logic          wr_acc, rd_acc;

  // A read frees a slot in the same edge, so a full FIFO still accepts a write.
  assign wr_acc = wr & (~full_q | rd);
  assign rd_acc = rd & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + W'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + W'(1);
      level_d = level_q + LW'(wr_acc) - LW'(rd_acc);
    end
  end

  // Flags are derived from the next level so they move on the same edge as level.
  always_comb begin
    empty_d = (level_d == '0);
    full_d  = (level_d == LW'(D));
    ae_d    = (level_d <= LW'(AE_LVL));
    af_d    = (level_d >= LW'(AF_LVL));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ae_q     <= 1'b1;
      af_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ae_q     <= ae_d;
      af_q     <= af_d;
    end
  end

  fifo_reg_file #(
    .B (B),
    .W (W)
  ) u_reg_file (
    .clk_i   (clk),
    .we_i    (wr_acc & ~flush),
    .waddr_i (wr_ptr_q),
    .wdata_i (w_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (r_data)
  );

  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_empty = ae_q;
  assign almost_full  = af_q;
  assign level        = level_q;

`ifdef UART_FIFO_ERR_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // Set wins over err_clr when both occur in one cycle.
  always_comb begin
    ovf_d = (wr & full_q & ~rd & ~flush) | (ovf_q & ~err_clr);
    unf_d = (rd & empty_q & ~flush) | (unf_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`endif

endmodule

// File: tb/tb_fifo_level.sv
// Self-checking bench for fifo_level (B=8, W=2): directed table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_fifo_level;

  localparam int unsigned B  = 8;
  localparam int unsigned W  = 2;
  localparam int unsigned D  = 4;
  localparam int unsigned AF = 2;
  localparam int unsigned AE = 1;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         flush, wr, rd, err_clr;
  logic [B-1:0] w_data, r_data;
  logic         empty, full, almost_empty, almost_full;
  logic [W:0]   level;
  logic         overflow, underflow;

  fifo_level #(
    .B      (B),
    .W      (W),
    .AF_LVL (AF),
    .AE_LVL (AE)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush        (flush),
    .wr           (wr),
    .w_data       (w_data),
    .rd           (rd),
`ifdef UART_FIFO_ERR_EN
    .err_clr      (err_clr),
    .overflow     (overflow),
    .underflow    (underflow),
`endif
    .r_data       (r_data),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .level        (level)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  byte unsigned mq[$];
  bit           m_ovf = 1'b0;
  bit           m_unf = 1'b0;

  typedef struct {
    bit       f, w, r;
    bit [7:0] d;
    int       lvl;
    bit       e, fu, ae, af, cr;
    bit [7:0] rexp;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: a bounded queue plus sticky error bits.
  task automatic model_edge();
    int n;
    bit ovf_set, unf_set;
    n       = mq.size();
    ovf_set = wr && (n == D) && !rd && !flush;
    unf_set = rd && (n == 0) && !flush;
    m_ovf   = ovf_set || (m_ovf && !err_clr);
    m_unf   = unf_set || (m_unf && !err_clr);
    if (flush) begin
      mq.delete();
    end else begin
      if (rd && n > 0) void'(mq.pop_front());
      if (wr && (n < D || rd)) mq.push_back(w_data);
    end
  endtask

  task automatic step(input bit f, input bit w, input bit r, input bit [7:0] d, input bit c);
    flush = f; wr = w; rd = r; w_data = d; err_clr = c;
    @(posedge clk);
    model_edge();
    #1;
    flush = 1'b0; wr = 1'b0; rd = 1'b0; err_clr = 1'b0;
  endtask

  task automatic check_err(input string tag);
`ifdef UART_FIFO_ERR_EN
    chk({tag, ".overflow"}, overflow, m_ovf);
    chk({tag, ".underflow"}, underflow, m_unf);
`else
    if (tag.len() == 0) $display("empty tag");
`endif
  endtask

  task automatic check_model(input string tag);
    int n;
    n = mq.size();
    chk({tag, ".level"}, level, n);
    chk({tag, ".empty"}, empty, n == 0);
    chk({tag, ".full"}, full, n == D);
    chk({tag, ".almost_empty"}, almost_empty, n <= AE);
    chk({tag, ".almost_full"}, almost_full, n >= AF);
    if (n > 0) chk({tag, ".r_data"}, r_data, mq[0]);
    check_err(tag);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".level"}, level, 0);
    chk({tag, ".empty"}, empty, 1);
    chk({tag, ".full"}, full, 0);
    chk({tag, ".almost_empty"}, almost_empty, 1);
    chk({tag, ".almost_full"}, almost_full, 0);
`ifdef UART_FIFO_ERR_EN
    chk({tag, ".overflow"}, overflow, 0);
    chk({tag, ".underflow"}, underflow, 0);
`endif
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    flush = 1'b0; wr = 1'b0; rd = 1'b0; err_clr = 1'b0; w_data = '0;
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  function automatic vec_t mk(bit f, bit w, bit r, bit [7:0] d, int lvl, bit e, bit fu,
                              bit ae, bit af, bit cr, bit [7:0] rexp);
    vec_t v;
    v.f = f; v.w = w; v.r = r; v.d = d; v.lvl = lvl; v.e = e; v.fu = fu;
    v.ae = ae; v.af = af; v.cr = cr; v.rexp = rexp;
    return v;
  endfunction

  initial begin
    // f w r data    lvl e fu ae af cr rexp
    tv.push_back(mk(0, 1, 0, 8'h11, 1, 0, 0, 1, 0, 1, 8'h11));
    tv.push_back(mk(0, 1, 0, 8'h22, 2, 0, 0, 0, 1, 1, 8'h11));
    tv.push_back(mk(0, 1, 0, 8'h33, 3, 0, 0, 0, 1, 1, 8'h11));
    tv.push_back(mk(0, 1, 0, 8'h44, 4, 0, 1, 0, 1, 1, 8'h11));
    tv.push_back(mk(0, 0, 1, 8'h00, 3, 0, 0, 0, 1, 1, 8'h22));
    tv.push_back(mk(0, 0, 1, 8'h00, 2, 0, 0, 0, 1, 1, 8'h33));
    tv.push_back(mk(0, 0, 1, 8'h00, 1, 0, 0, 1, 0, 1, 8'h44));
    tv.push_back(mk(0, 0, 1, 8'h00, 0, 1, 0, 1, 0, 0, 8'h00));
    tv.push_back(mk(0, 1, 0, 8'h11, 1, 0, 0, 1, 0, 1, 8'h11));
    tv.push_back(mk(0, 1, 0, 8'h22, 2, 0, 0, 0, 1, 1, 8'h11));
    tv.push_back(mk(0, 1, 0, 8'h33, 3, 0, 0, 0, 1, 1, 8'h11));
    tv.push_back(mk(0, 1, 0, 8'h44, 4, 0, 1, 0, 1, 1, 8'h11));
    tv.push_back(mk(0, 1, 1, 8'h55, 4, 0, 1, 0, 1, 1, 8'h22));
    tv.push_back(mk(0, 0, 1, 8'h00, 3, 0, 0, 0, 1, 1, 8'h33));
    tv.push_back(mk(0, 0, 1, 8'h00, 2, 0, 0, 0, 1, 1, 8'h44));
    tv.push_back(mk(0, 0, 1, 8'h00, 1, 0, 0, 1, 0, 1, 8'h55));
    tv.push_back(mk(0, 0, 1, 8'h00, 0, 1, 0, 1, 0, 0, 8'h00));
    tv.push_back(mk(0, 1, 1, 8'hA5, 1, 0, 0, 1, 0, 1, 8'hA5));
    tv.push_back(mk(0, 0, 1, 8'h00, 0, 1, 0, 1, 0, 0, 8'h00));

    reset_n = 1'b0;
    flush = 1'b0; wr = 1'b0; rd = 1'b0; err_clr = 1'b0; w_data = '0;
    #12;
    check_reset_vals("reset");
    @(negedge clk);
    reset_n = 1'b1;

    foreach (tv[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      step(tv[i].f, tv[i].w, tv[i].r, tv[i].d, 1'b0);
      chk({tag, ".level"}, level, tv[i].lvl);
      chk({tag, ".empty"}, empty, tv[i].e);
      chk({tag, ".full"}, full, tv[i].fu);
      chk({tag, ".almost_empty"}, almost_empty, tv[i].ae);
      chk({tag, ".almost_full"}, almost_full, tv[i].af);
      if (tv[i].cr) chk({tag, ".r_data"}, r_data, tv[i].rexp);
      check_err(tag);
    end

    // Wrap-around: write-then-read repeatedly on a 4-deep FIFO.
    for (int i = 0; i < 10; i++) begin
      bit [7:0] d;
      d = 8'(i * 7 + 3);
      step(0, 1, 0, d, 0);
      chk("wrap.level1", level, 1);
      chk("wrap.r_data", r_data, d);
      step(0, 0, 1, 8'h00, 0);
      chk("wrap.level0", level, 0);
      chk("wrap.empty", empty, 1);
    end

    // Flush drops a concurrent write; storage order afterwards is intact.
    step(0, 1, 0, 8'hAA, 0);
    step(0, 1, 0, 8'hBB, 0);
    step(0, 1, 0, 8'hCC, 0);
    chk("flush.pre_level", level, 3);
    step(1, 1, 0, 8'h77, 0);
    chk("flush.level", level, 0);
    chk("flush.empty", empty, 1);
    chk("flush.almost_empty", almost_empty, 1);
    chk("flush.almost_full", almost_full, 0);
    chk("flush.full", full, 0);
`ifdef UART_FIFO_ERR_EN
    chk("flush.overflow", overflow, 0);
`endif
    step(0, 0, 0, 8'h00, 0);
    chk("flush.dropped", level, 0);

    for (int i = 1; i <= 4; i++) step(0, 1, 0, 8'(i), 0);
    step(0, 1, 0, 8'h99, 0);
    chk("ovf.level", level, 4);
    chk("ovf.r_data", r_data, 8'h01);
`ifdef UART_FIFO_ERR_EN
    chk("ovf.set", overflow, 1);
`endif
    step(0, 0, 0, 8'h00, 0);
    check_model("ovf.hold");
    step(0, 1, 0, 8'h98, 1);
    check_model("ovf.set_wins");
    step(0, 0, 0, 8'h00, 1);
    check_model("ovf.clr");
    for (int i = 1; i <= 4; i++) begin
      chk("ovf.drain", r_data, 8'(i));
      step(0, 0, 1, 8'h00, 0);
    end
    chk("ovf.drained_empty", empty, 1);

    // Asynchronous reset mid-burst, checked before the next clock edge.
    do_reset();
    step(0, 1, 0, 8'h5A, 0);
    step(0, 1, 0, 8'h6B, 0);
    chk("areset.pre_level", level, 2);
    wr = 1'b1; w_data = 8'h7C;
    #2;
    reset_n = 1'b0;
    wr = 1'b0;
    #1;
    check_reset_vals("areset");
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // Randomized traffic: write-heavy then read-heavy to reach both full and empty.
    for (int i = 0; i < 400; i++) begin
      bit f, w, r, c;
      int wp;
      wp = (i < 200) ? 70 : 30;
      f  = ($urandom_range(0, 31) == 0);
      w  = ($urandom_range(0, 99) < wp);
      r  = ($urandom_range(0, 99) < 50);
      c  = ($urandom_range(0, 15) == 0);
      step(f, w, r, 8'($urandom), c);
      check_model($sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_level.md
# fifo_level

Parametrised synchronous FIFO for the UART core's TX and RX buffering. It adds the following over the basic buffer:
- occupancy count and programmable almost-full/almost-empty thresholds;
- synchronous flush;
- write accepted on a full FIFO when a read occurs in the same cycle;
- optional sticky overflow/underflow error flags.

It sits between the UART TX/RX engines and the host-side register interface.

## Interface
- `B`, 8, data word width in bits
- `W`, 4, address bits; depth `D = 2**W` words
- `AF_LVL`, `2**W-2`, almost_full asserts when level >= AF_LVL (1..D)
- `AE_LVL`, 1, almost_empty asserts when level <= AE_LVL (0..D-1)

- `clk`  in  1  single clock; all state updates on rising edge
- `reset_n`  in  1  reset, asynchronous, active-low
- `flush`  in  1  synchronous clear of contents
- `wr`  in  1  write request
- `w_data`  in  B  write data
- `rd`  in  1  read request; pops the word currently on r_data
- `r_data`  out  B  head-of-queue word (show-ahead)
- `empty`  out  1  level == 0
- `full`  out  1  level == D
- `almost_empty`  out  1  level <= AE_LVL
- `almost_full`  out  1  level >= AF_LVL
- `level`  out  W+1  words currently stored, 0..D
- `overflow`  out  1  sticky: write rejected (only with UART_FIFO_ERR_EN)
- `underflow`  out  1  sticky: read on empty (only with UART_FIFO_ERR_EN)
- `err_clr`  in  1  clears overflow/underflow (only with UART_FIFO_ERR_EN)

## Operation
- **State:** write pointer, read pointer (W bits each, natural wrap D-1 -> 0), level register (W+1 bits), registered status flags.
- **Accept rules:**
  - `wr_acc = wr & (~full | rd)`
  - `rd_acc = rd & ~empty`
  - Write on a full FIFO with a simultaneous read is accepted: both pointers advance and level is unchanged.
  - rd & wr on an empty FIFO: the write is accepted, the read is rejected, level goes to 1.
- **Level update:** `level_next = level + wr_acc - rd_acc`. It never exceeds D and never goes below 0.
- **Flags:** all flags are registered and computed from `level_next`, so they change on the same edge as `level`.
- **Storage:** written at `w_ptr` on `wr_acc`. Storage is not reset. `r_data = mem[r_ptr]` combinationally; its value is don't-care while empty.
- **Flush:** has priority over rd and wr. On the next edge:
  - pointers and level go to 0, empty = 1, almost_empty = 1, all other status flags = 0;
  - a write in the same cycle is dropped and is not counted as overflow;
  - storage is untouched.
- **Reset (reset_n low, any time):** pointers = 0, level = 0, empty = 1, almost_empty = 1, full = 0, almost_full = 0, overflow = 0, underflow = 0. An operation in progress is discarded.
- **Threshold parameters:** out-of-range values are a configuration error and are caught by an elaboration-time check.

## Timing
- Write-to-read latency is 1 cycle: the word written at edge N is on `r_data`, with empty = 0, after edge N.
- A read takes effect at the edge. The next word appears on `r_data` after that edge, with no bubble.
- Back-to-back rd & wr every cycle sustains 1 word/cycle at any level, including full.
- All status outputs change only on clk edges, except the asynchronous assertion of reset.

## Configuration
- `UART_FIFO_ERR_EN` defined:
  - overflow sets on `wr & full & ~rd & ~flush`;
  - underflow sets on `rd & empty & ~flush`;
  - both hold until err_clr, or reset;
  - if err_clr and a set condition coincide, set wins.
- `UART_FIFO_ERR_EN` undefined: overflow, underflow and err_clr ports are absent. Rejected requests are silently ignored.

## Structure
- **Shared package `uart_fifo_pkg`:** default B/W, the level-width helper (`W+1`), and the threshold range-check constants.
- **Sub-module `fifo_reg_file`:** dual-port register array with one synchronous write port and one combinational read port. The control logic (pointers, level, flags, error flags) lives in `fifo_level`.

## Test plan
- **Fill/drain (B=8, W=2):** reset, write 0x11, 0x22, 0x33, 0x44.
  - level 1, 2, 3, 4; almost_full (AF_LVL=2) at level 2; full at 4.
  - Read 4 times: r_data 0x11..0x44 in order; empty after the 4th read.
- **Full with simultaneous rd & wr:** full FIFO holding 0x11..0x44, rd & wr 0x55.
  - level stays 4, r_data becomes 0x22, no overflow.
  - After draining: order 0x22, 0x33, 0x44, 0x55.
- **Empty with simultaneous rd & wr:** empty FIFO, rd & wr 0xA5 -> level 1, r_data 0xA5, underflow = 1 (ERR_EN).
- **Wrap-around:** 10 cycles of write-then-read on W=2 -> pointers wrap twice, data intact, level toggles 1/0.
- **Flush and errors:** level 3, flush & wr 0x77 -> level 0, empty = 1, overflow = 0.
  - Write on full with rd = 0 -> overflow = 1 until err_clr.
- **Async reset:** assert reset_n low mid-burst at level 2 -> all outputs at reset values immediately, before the next clk edge.
